// File: rtl/hash_stream_merger.sv
// hash_stream_merger
// Merges NUM_HASHER independently hashed lanes back into one stream in strictly
// ascending serial order. Each lane has a one-entry hold register, and a single
// output register feeds the downstream partitioner. End-of-stream is reported
// once every lane has delivered its last beat.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_RUN   | accepting lane beats, emitting them in serial order
// ST_DRAIN | final beat of the whole stream is in the output register
// ST_DONE  | final beat has handshaken; lanes blocked, out_done high
module hash_stream_merger #(
    parameter int NUM_HASHER = 8,
    parameter int SERIAL_W   = 64
) (
    input  logic                           clk,
    input  logic                           resetn,
    output logic [NUM_HASHER-1:0]          in_ready,
    input  logic [NUM_HASHER*64-1:0]       in_tuple,
    input  logic [NUM_HASHER*32-1:0]       in_tag,
    input  logic [NUM_HASHER-1:0]          in_valid,
    input  logic [NUM_HASHER-1:0]          in_last_processed,
    input  logic [NUM_HASHER*SERIAL_W-1:0] in_serialnum,
    input  logic                           clear,
    input  logic                           out_ready,
    output logic                           out_valid,
    output logic [63:0]                    out_tuple,
    output logic [31:0]                    out_tag,
    output logic [SERIAL_W-1:0]            out_serialnum,
    output logic                           out_last_processed,
    output logic                           out_done,
    output logic                           err_dup_serial
);

    localparam int LANE_W = (NUM_HASHER > 1) ? $clog2(NUM_HASHER) : 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t state;

    logic [NUM_HASHER-1:0] hold_v;
    logic [NUM_HASHER-1:0] hold_last;
    logic [63:0]           hold_tuple  [NUM_HASHER];
    logic [31:0]           hold_tag    [NUM_HASHER];
    logic [SERIAL_W-1:0]   hold_serial [NUM_HASHER];

    logic [SERIAL_W-1:0]   expected;
    logic [NUM_HASHER-1:0] lane_done;

    logic [NUM_HASHER-1:0] accept;
    logic [NUM_HASHER-1:0] accept_live;
    logic [NUM_HASHER-1:0] accept_dead;
    logic [NUM_HASHER-1:0] cand;
    logic [NUM_HASHER-1:0] hold_v_nxt;
    logic [LANE_W-1:0]     sel;
    logic                  multi_cand;
    logic                  load;
    logic                  last_of_stream;
    logic                  out_fire;

    function automatic int popcount(input logic [NUM_HASHER-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < NUM_HASHER; i++) begin
            n = n + int'(v[i]);
        end
        return n;
    endfunction

    // Candidate selection, load decision and next hold occupancy.
    always_comb begin
        accept      = in_valid & in_ready;
        // A lane that already delivered its last beat must stay silent;
        // anything it still sends is discarded and flagged.
        accept_live = accept & ~lane_done;
        accept_dead = accept & lane_done;

        cand = '0;
        for (int i = 0; i < NUM_HASHER; i++) begin
            cand[i] = hold_v[i] && (hold_serial[i] == expected);
        end

        // Lowest index wins when two lanes claim the same serial.
        sel = '0;
        for (int i = NUM_HASHER - 1; i >= 0; i--) begin
            if (cand[i]) begin
                sel = LANE_W'(i);
            end
        end
        multi_cand = (cand & (cand - NUM_HASHER'(1))) != '0;

        out_fire       = out_valid && out_ready;
        load           = (state == ST_RUN) && (cand != '0) && (!out_valid || out_ready);
        last_of_stream = hold_last[sel] && (popcount(lane_done) == NUM_HASHER - 1);

        hold_v_nxt = hold_v | accept_live;
        if (load) begin
            hold_v_nxt[sel] = 1'b0;
        end
    end

    // Per-lane hold registers: capture accepted beats, release on load.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold_v    <= '0;
            hold_last <= '0;
            for (int i = 0; i < NUM_HASHER; i++) begin
                hold_tuple[i]  <= '0;
                hold_tag[i]    <= '0;
                hold_serial[i] <= '0;
            end
        end else if (clear) begin
            hold_v <= '0;
        end else begin
            hold_v <= hold_v_nxt;
            for (int i = 0; i < NUM_HASHER; i++) begin
                if (accept_live[i]) begin
                    hold_tuple[i]  <= in_tuple[i*64 +: 64];
                    hold_tag[i]    <= in_tag[i*32 +: 32];
                    hold_serial[i] <= in_serialnum[i*SERIAL_W +: SERIAL_W];
                    hold_last[i]   <= in_last_processed[i];
                end
            end
        end
    end

    // Sequencing FSM with the output register, expected serial and status flags.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state              <= ST_RUN;
            expected           <= '0;
            lane_done          <= '0;
            in_ready           <= '0;
            out_valid          <= 1'b0;
            out_tuple          <= '0;
            out_tag            <= '0;
            out_serialnum      <= '0;
            out_last_processed <= 1'b0;
            out_done           <= 1'b0;
            err_dup_serial     <= 1'b0;
        end else if (clear) begin
            // Restart wins over any handshake in the same cycle.
            state              <= ST_RUN;
            expected           <= '0;
            lane_done          <= '0;
            in_ready           <= '1;
            out_valid          <= 1'b0;
            out_tuple          <= '0;
            out_tag            <= '0;
            out_serialnum      <= '0;
            out_last_processed <= 1'b0;
            out_done           <= 1'b0;
            err_dup_serial     <= 1'b0;
        end else begin
            if (load) begin
                out_valid          <= 1'b1;
                out_tuple          <= hold_tuple[sel];
                out_tag            <= hold_tag[sel];
                out_serialnum      <= hold_serial[sel];
                out_last_processed <= last_of_stream;
                expected           <= expected + SERIAL_W'(1);
                if (hold_last[sel]) begin
                    lane_done[sel] <= 1'b1;
                end
            end else if (out_ready) begin
                out_valid          <= 1'b0;
                out_last_processed <= 1'b0;
            end

            if ((load && multi_cand) || (accept_dead != '0)) begin
                err_dup_serial <= 1'b1;
            end

            // Ready depends only on registered state, never on out_ready.
            if (state == ST_RUN && !(load && last_of_stream)) begin
                in_ready <= ~hold_v_nxt;
            end else begin
                in_ready <= '0;
            end

            case (state)
                ST_RUN: begin
                    if (load && last_of_stream) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (out_fire && out_last_processed) begin
                        state    <= ST_DONE;
                        out_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    out_done <= 1'b1;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hash_stream_merger.sv
// Directed bench for hash_stream_merger: a 4-lane, 64-bit-serial instance for
// ordering, stall, backpressure, duplicate, reset and clear behaviour, plus a
// 2-lane, 3-bit-serial instance to exercise expected-serial wrap-around.
module tb_hash_stream_merger;

    localparam int N   = 4;
    localparam int SW  = 64;
    localparam int WN  = 2;
    localparam int WSW = 3;

    typedef struct packed {
        logic [63:0] serial;
        logic [63:0] tuple;
        logic [31:0] tag;
        logic        last;
        logic        exp_last;
    } beat_t;

    logic              clk;
    logic              resetn;
    logic              clear;
    logic              out_ready;
    logic [N-1:0]      in_ready;
    logic [N-1:0]      in_valid;
    logic [N-1:0]      in_last_processed;
    logic [N*64-1:0]   in_tuple;
    logic [N*32-1:0]   in_tag;
    logic [N*SW-1:0]   in_serialnum;
    logic              out_valid;
    logic [63:0]       out_tuple;
    logic [31:0]       out_tag;
    logic [SW-1:0]     out_serialnum;
    logic              out_last_processed;
    logic              out_done;
    logic              err_dup_serial;

    logic              w_clear;
    logic              w_out_ready;
    logic [WN-1:0]     w_in_ready;
    logic [WN-1:0]     w_in_valid;
    logic [WN-1:0]     w_in_last_processed;
    logic [WN*64-1:0]  w_in_tuple;
    logic [WN*32-1:0]  w_in_tag;
    logic [WN*WSW-1:0] w_in_serialnum;
    logic              w_out_valid;
    logic [63:0]       w_out_tuple;
    logic [31:0]       w_out_tag;
    logic [WSW-1:0]    w_out_serialnum;
    logic              w_out_last_processed;
    logic              w_out_done;
    logic              w_err_dup_serial;

    hash_stream_merger #(.NUM_HASHER(N), .SERIAL_W(SW)) dut (
        .clk(clk), .resetn(resetn), .in_ready(in_ready), .in_tuple(in_tuple),
        .in_tag(in_tag), .in_valid(in_valid), .in_last_processed(in_last_processed),
        .in_serialnum(in_serialnum), .clear(clear), .out_ready(out_ready),
        .out_valid(out_valid), .out_tuple(out_tuple), .out_tag(out_tag),
        .out_serialnum(out_serialnum), .out_last_processed(out_last_processed),
        .out_done(out_done), .err_dup_serial(err_dup_serial)
    );

    hash_stream_merger #(.NUM_HASHER(WN), .SERIAL_W(WSW)) dut_wrap (
        .clk(clk), .resetn(resetn), .in_ready(w_in_ready), .in_tuple(w_in_tuple),
        .in_tag(w_in_tag), .in_valid(w_in_valid), .in_last_processed(w_in_last_processed),
        .in_serialnum(w_in_serialnum), .clear(w_clear), .out_ready(w_out_ready),
        .out_valid(w_out_valid), .out_tuple(w_out_tuple), .out_tag(w_out_tag),
        .out_serialnum(w_out_serialnum), .out_last_processed(w_out_last_processed),
        .out_done(w_out_done), .err_dup_serial(w_err_dup_serial)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    int          cycle    = 0;
    int          n_out, first_cyc, last_cyc;
    int          w_n_out, w_first_cyc, w_last_cyc;
    logic [63:0] exp_ser;
    logic [2:0]  w_exp;
    logic        want_ready;
    logic [N-1:0] lane_en;
    beat_t       lane_q [N][$];
    beat_t       sb_q [$];
    beat_t       w_lane_q [WN][$];
    beat_t       w_sb_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic add_beat(input int lane, input logic [63:0] ser, input logic last,
                            input logic exp_last);
        beat_t b;
        b.serial   = ser;
        b.tuple    = {$urandom, $urandom};
        b.tag      = $urandom;
        b.last     = last;
        b.exp_last = exp_last;
        lane_q[lane].push_back(b);
    endtask

    task automatic add_wbeat(input int lane, input logic [63:0] ser, input logic last,
                             input logic exp_last);
        beat_t b;
        b.serial   = ser;
        b.tuple    = {$urandom, $urandom};
        b.tag      = $urandom;
        b.last     = last;
        b.exp_last = exp_last;
        w_lane_q[lane].push_back(b);
    endtask

    // Lane i carries serials i, i+4, i+8; the lane's final beat is flagged last.
    task automatic add_stream();
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 3; k++) begin
                add_beat(i, 64'(i + 4 * k), k == 2, (i + 4 * k) == 11);
            end
        end
    endtask

    // Output beats must arrive in ascending serial order with the data pushed earlier.
    task automatic check_out();
        int idx;
        idx = -1;
        for (int k = 0; k < sb_q.size(); k++) begin
            if (idx < 0 && sb_q[k].serial == exp_ser) idx = k;
        end
        chk("out_serial_known", 64'(idx >= 0), 64'd1);
        chk("out_serial", out_serialnum, exp_ser);
        if (idx >= 0) begin
            chk("out_tuple", out_tuple, sb_q[idx].tuple);
            chk("out_tag", 64'(out_tag), 64'(sb_q[idx].tag));
            chk("out_last", 64'(out_last_processed), 64'(sb_q[idx].exp_last));
            sb_q.delete(idx);
        end
        if (n_out == 0) first_cyc = cycle;
        last_cyc = cycle;
        n_out++;
        exp_ser = exp_ser + 64'd1;
    endtask

    task automatic check_wout();
        int idx;
        idx = -1;
        for (int k = 0; k < w_sb_q.size(); k++) begin
            if (idx < 0 && w_sb_q[k].serial == 64'(w_exp)) idx = k;
        end
        chk("wrap_serial_known", 64'(idx >= 0), 64'd1);
        chk("wrap_serial", 64'(w_out_serialnum), 64'(w_exp));
        if (idx >= 0) begin
            chk("wrap_tuple", w_out_tuple, w_sb_q[idx].tuple);
            chk("wrap_last", 64'(w_out_last_processed), 64'(w_sb_q[idx].exp_last));
            w_sb_q.delete(idx);
        end
        if (w_n_out == 0) w_first_cyc = cycle;
        w_last_cyc = cycle;
        w_n_out++;
        w_exp = w_exp + 3'd1;
    endtask

    // One clock: check the output handshake due at the next edge, drive lanes,
    // and move every beat the DUT will accept into the scoreboard.
    task automatic step();
        @(negedge clk);
        cycle++;
        out_ready = want_ready;
        if (out_valid && out_ready) check_out();
        if (w_out_valid && w_out_ready) check_wout();
        for (int i = 0; i < N; i++) begin
            if (lane_en[i] && lane_q[i].size() > 0) begin
                in_valid[i]               = 1'b1;
                in_tuple[i*64 +: 64]      = lane_q[i][0].tuple;
                in_tag[i*32 +: 32]        = lane_q[i][0].tag;
                in_serialnum[i*SW +: SW]  = lane_q[i][0].serial;
                in_last_processed[i]      = lane_q[i][0].last;
            end else begin
                in_valid[i]          = 1'b0;
                in_last_processed[i] = 1'b0;
            end
            if (in_valid[i] && in_ready[i]) sb_q.push_back(lane_q[i].pop_front());
        end
        for (int i = 0; i < WN; i++) begin
            if (w_lane_q[i].size() > 0) begin
                w_in_valid[i]               = 1'b1;
                w_in_tuple[i*64 +: 64]      = w_lane_q[i][0].tuple;
                w_in_tag[i*32 +: 32]        = w_lane_q[i][0].tag;
                w_in_serialnum[i*WSW +: WSW] = w_lane_q[i][0].serial[2:0];
                w_in_last_processed[i]      = w_lane_q[i][0].last;
            end else begin
                w_in_valid[i]          = 1'b0;
                w_in_last_processed[i] = 1'b0;
            end
            if (w_in_valid[i] && w_in_ready[i]) w_sb_q.push_back(w_lane_q[i].pop_front());
        end
    endtask

    task automatic run_until(input string tag, input int target, input int budget);
        int b;
        b = 0;
        while (n_out < target && b < budget) begin
            step();
            b++;
        end
        chk(tag, 64'(n_out), 64'(target));
    endtask

    task automatic wait_done(input string tag, input int budget);
        int b;
        b = 0;
        while (!out_done && b < budget) begin
            step();
            b++;
        end
        chk(tag, 64'(out_done), 64'd1);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        exp_ser = '0;
        n_out   = 0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_out_serial"}, out_serialnum, 64'd0);
        chk({tag, "_out_tuple"}, out_tuple, 64'd0);
        chk({tag, "_out_tag"}, 64'(out_tag), 64'd0);
        chk({tag, "_out_last"}, 64'(out_last_processed), 64'd0);
        chk({tag, "_out_done"}, 64'(out_done), 64'd0);
        chk({tag, "_err"}, 64'(err_dup_serial), 64'd0);
    endtask

    initial begin
        logic [63:0] snap_tuple, snap_ser;
        logic [31:0] snap_tag;
        logic        stable, any_valid, ready_leak;

        resetn = 1'b0; clear = 1'b0; out_ready = 1'b0; want_ready = 1'b1;
        in_valid = '0; in_last_processed = '0; in_tuple = '0; in_tag = '0; in_serialnum = '0;
        w_clear = 1'b0; w_out_ready = 1'b1;
        w_in_valid = '0; w_in_last_processed = '0; w_in_tuple = '0; w_in_tag = '0;
        w_in_serialnum = '0;
        lane_en = '1; exp_ser = '0; n_out = 0; w_exp = '0; w_n_out = 0;
        first_cyc = 0; last_cyc = 0; w_first_cyc = 0; w_last_cyc = 0;

        // Reset state.
        step(); step();
        check_idle("reset");
        resetn = 1'b1;
        step(); step();
        chk("post_reset_in_ready", 64'(in_ready), 64'hF);

        // Interleaved full stream: 0..11, one per cycle, last only on 11.
        add_stream();
        run_until("s1_count", 12, 60);
        chk("s1_one_per_cycle", 64'(last_cyc - first_cyc), 64'd11);
        wait_done("s1_done", 4);
        chk("s1_done_in_ready", 64'(in_ready), 64'd0);
        chk("s1_done_out_valid", 64'(out_valid), 64'd0);

        // Clear from DONE restarts everything.
        do_clear();
        chk("clr_out_done", 64'(out_done), 64'd0);
        chk("clr_in_ready", 64'(in_ready), 64'hF);
        chk("clr_out_valid", 64'(out_valid), 64'd0);

        // Lane 0 stalls on serial 0 while lanes 1..3 hold 1..3.
        lane_en[0] = 1'b0;
        for (int i = 0; i < N; i++) add_beat(i, 64'(i), 1'b0, 1'b0);
        any_valid = 1'b0; ready_leak = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            any_valid = any_valid | out_valid;
            if (i >= 1) ready_leak = ready_leak | (|in_ready[3:1]);
        end
        chk("s2_no_out_valid", 64'(any_valid), 64'd0);
        chk("s2_held_not_ready", 64'(ready_leak), 64'd0);
        lane_en[0] = 1'b1;
        run_until("s2_count", 4, 20);
        chk("s2_back_to_back", 64'(last_cyc - first_cyc), 64'd3);

        // Backpressure mid-stream: serials 4..11.
        n_out = 0;
        for (int i = 0; i < N; i++) begin
            add_beat(i, 64'(4 + i), 1'b0, 1'b0);
            add_beat(i, 64'(8 + i), 1'b0, 1'b0);
        end
        run_until("s3_pre", 3, 30);
        want_ready = 1'b0;
        step();
        snap_tuple = out_tuple; snap_tag = out_tag; snap_ser = out_serialnum;
        chk("s3_stalled_valid", 64'(out_valid), 64'd1);
        stable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            stable = stable & out_valid & (out_tuple == snap_tuple) &
                     (out_tag == snap_tag) & (out_serialnum == snap_ser);
        end
        chk("s3_stable", 64'(stable), 64'd1);
        want_ready = 1'b1;
        run_until("s3_count", 8, 40);
        for (int i = 0; i < 4; i++) step();
        chk("s3_no_extra", 64'(n_out), 64'd8);
        chk("s3_sb_empty", 64'(sb_q.size()), 64'd0);

        // Duplicate serial: lanes 1 and 2 both hold 5 when 5 is expected.
        do_clear();
        add_beat(0, 64'd0, 1'b0, 1'b0);
        add_beat(0, 64'd4, 1'b0, 1'b0);
        for (int i = 1; i < N; i++) add_beat(i, 64'(i), 1'b0, 1'b0);
        run_until("s4_pre", 5, 30);
        chk("s4_err_before", 64'(err_dup_serial), 64'd0);
        add_beat(1, 64'd5, 1'b0, 1'b0);
        add_beat(2, 64'd5, 1'b0, 1'b0);
        run_until("s4_dup_out", 6, 20);
        chk("s4_err_set", 64'(err_dup_serial), 64'd1);
        add_beat(3, 64'd6, 1'b0, 1'b0);
        run_until("s4_after", 7, 20);
        step(); step();
        chk("s4_err_sticky", 64'(err_dup_serial), 64'd1);
        chk("s4_lane2_held", 64'(in_ready[2]), 64'd0);
        do_clear();
        sb_q.delete();
        chk("s4_err_cleared", 64'(err_dup_serial), 64'd0);
        chk("s4_clr_in_ready", 64'(in_ready), 64'hF);

        // Reset mid-stream discards everything in flight.
        add_stream();
        for (int i = 0; i < 5; i++) step();
        resetn = 1'b0;
        #1;
        check_idle("midreset");
        for (int i = 0; i < N; i++) lane_q[i].delete();
        sb_q.delete();
        step(); step();
        chk("midreset_hold_valid", 64'(out_valid), 64'd0);
        chk("midreset_hold_ready", 64'(in_ready), 64'd0);
        resetn = 1'b1;
        exp_ser = '0; n_out = 0;
        step(); step();
        chk("s5_ready_after_reset", 64'(in_ready), 64'hF);
        chk("s5_no_stray_out", 64'(n_out), 64'd0);
        add_stream();
        run_until("s5_count", 12, 60);
        wait_done("s5_done", 4);
        do_clear();
        chk("s5_clr_done", 64'(out_done), 64'd0);
        for (int i = 0; i < N; i++) add_beat(i, 64'(i), 1'b1, i == N - 1);
        run_until("s5_short_count", 4, 30);
        wait_done("s5_short_done", 4);

        // Wrap-around on the 3-bit instance: 0..7 then 0,1 with no stall.
        for (int k = 0; k < 5; k++) begin
            add_wbeat(0, 64'((2 * k) % 8), k == 4, 1'b0);
            add_wbeat(1, 64'((2 * k + 1) % 8), k == 4, k == 4);
        end
        begin
            int b;
            b = 0;
            while (w_n_out < 10 && b < 60) begin
                step();
                b++;
            end
        end
        chk("wrap_count", 64'(w_n_out), 64'd10);
        chk("wrap_no_stall", 64'(w_last_cyc - w_first_cyc), 64'd9);
        step(); step();
        chk("wrap_done", 64'(w_out_done), 64'd1);
        chk("wrap_err", 64'(w_err_dup_serial), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hash_stream_merger.md
Name: hash_stream_merger

Overview:
- Downstream consumer of the parallel murmur hasher bank.
- Accepts NUM_HASHER independent hashed streams (tuple, 32-bit tag, serial number, last flag) and merges them into one stream ordered strictly by ascending serial number.
- Restores original input order for the partitioner that follows.
- Reports end-of-stream once every lane has delivered its last beat.

Parameters:
- NUM_HASHER, 8, number of input lanes (2..16).
- SERIAL_W, 64, serial number width; the expected-serial counter uses this width.

Ports:
- clk  input  1  clock
- resetn  input  1  asynchronous active-low reset
- in_ready  output  NUM_HASHER  per-lane ready toward hasher out_ready
- in_tuple  input  NUM_HASHERx64  per-lane tuple
- in_tag  input  NUM_HASHERx32  per-lane hash tag
- in_valid  input  NUM_HASHER  per-lane valid
- in_last_processed  input  NUM_HASHER  marks final beat of that lane
- in_serialnum  input  NUM_HASHERxSERIAL_W  per-lane serial number
- clear  input  1  synchronous restart: flush state, expected serial to 0
- out_ready  input  1  downstream ready
- out_valid  output  1  merged beat valid
- out_tuple  output  64  merged tuple
- out_tag  output  32  merged tag
- out_serialnum  output  SERIAL_W  merged serial
- out_last_processed  output  1  final beat of whole stream
- out_done  output  1  high in DONE state
- err_dup_serial  output  1  sticky: two held lanes carried the same expected serial

Behaviour:
- Clock and reset: one clock, clk. resetn is asynchronous and active-low.
- Reset values: all outputs 0; in_ready all 0 during reset; hold registers empty; expected serial 0; lane_done all 0; state RUN.
- Per-lane hold register (1 entry):
  - in_ready[i] = RUN && !hold_v[i], registered-source only, with no combinational path from out_ready.
  - A beat is accepted when in_valid[i] && in_ready[i].
- Output register (1 entry):
  - Loads when (!out_valid || out_ready).
  - out_* stay stable while out_valid && !out_ready.
- Selection:
  - Candidate lane = hold_v[i] && hold_serial[i] == expected.
  - On load, the candidate moves to the output register, its hold_v clears, and expected increments by 1 (wraps modulo 2^SERIAL_W).
  - With no candidate, nothing loads and the block waits with no timeout.
  - If more than one candidate exists, pick the lowest index and set err_dup_serial.
- Latency: a beat accepted in cycle t appears on out_valid no earlier than t+2. Aggregate throughput is 1 beat/cycle when serials are interleaved across lanes; per-lane max is 1 beat per 2 cycles.
- Last handling:
  - When a beat with hold_last[i] is loaded, lane_done[i] sets.
  - out_last_processed = hold_last of the loaded beat && popcount(lane_done before load) == NUM_HASHER-1.
  - A lane that has set lane_done must not send further beats. Any beat accepted on a done lane is dropped and sets err_dup_serial.
- FSM:
  - RUN -> DRAIN when the out_last_processed beat loads.
  - DRAIN -> DONE when that beat handshakes.
  - DONE holds; in_ready = 0; out_done = 1.
  - clear in any state -> RUN: flushes hold and output registers (out_valid drops next cycle), zeroes expected, lane_done and err_dup_serial.
  - clear has priority over a simultaneous handshake.
- Reset mid-operation discards all held beats with no output.

Test Plan:
- NUM_HASHER=4; lane i sends serials i, i+4, i+8; lane i sets last on its final beat; out_ready=1 -> out_serialnum 0..11 in order, one per cycle after startup; out_last_processed only on serial 11; out_done=1 two cycles later.
- Lane 0 delayed 20 cycles holding serial 0, others presenting 1,2,3 -> no out_valid for 20 cycles; then 0,1,2,3 back-to-back; in_ready[1..3] stay low while held.
- Backpressure: out_ready low 5 cycles mid-stream -> out_tuple/tag/serial constant; no beat lost or duplicated; order preserved.
- Lanes 1 and 2 both presenting serial 5 when expected=5 -> lane 1 emitted, err_dup_serial=1 sticky until clear.
- Expected preset near wrap (serials 2^64-2, 2^64-1, 0, 1) -> emitted in that order, with no stall at the wrap.
- resetn pulsed low mid-stream, then clear asserted in DONE -> all outputs 0 / in_ready 0 during reset; after clear, state RUN, expected 0, new stream merges correctly.
